// File: rtl/chiplib_pri_queue_push_ctl.sv
// Two-entry in-order skid buffer between an upstream push port and a priority queue core.
// Define CHIPLIB_PRI_QUEUE_PUSH_STATS_EN to add saturating accept/stall statistics counters.
module chiplib_pri_queue_push_ctl #(
  parameter int DataWidth     = 64,
  parameter int PriorityWidth = 16,
  parameter int StatWidth     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DataWidth-1:0]     push_data,
  input  logic [PriorityWidth-1:0] push_pri,
  input  logic                     push_valid,
  output logic                     push_ready,
  output logic                     queue_push_valid,
  output logic [DataWidth-1:0]     queue_push_data,
  output logic [PriorityWidth-1:0] queue_push_pri,
  input  logic                     full,
  input  logic                     flush
`ifdef CHIPLIB_PRI_QUEUE_PUSH_STATS_EN
  ,
  output logic [StatWidth-1:0]     stat_accept_count,
  output logic [StatWidth-1:0]     stat_stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // head is the oldest entry and is always the one presented to the core
  logic [DataWidth-1:0]     head_data_p1, tail_data_p1;
  logic [PriorityWidth-1:0] head_pri_p1, tail_pri_p1;

  logic accept;
  logic write;

  assign accept = push_valid & push_ready;
  assign write  = (state_q != EMPTY) & ~full & ~flush & ~rst;

  // Stage boundary: control state and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      push_ready <= 1'b1;
    end else begin
      state_q    <= state_d;
      push_ready <= (state_d != TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          if (accept && !write)      state_d = TWO;
          else if (!accept && write) state_d = EMPTY;
        end
        TWO:     if (write) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    queue_push_valid = write;
    queue_push_data  = head_data_p1;
    queue_push_pri   = head_pri_p1;
  end

  // Stage boundary: payload slots, never reset; occupancy lives in state_q
  always_ff @(posedge clk) begin
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_data_p1 <= push_data;
          head_pri_p1  <= push_pri;
        end
      end
      ONE: begin
        if (accept && write) begin
          head_data_p1 <= push_data;
          head_pri_p1  <= push_pri;
        end else if (accept) begin
          tail_data_p1 <= push_data;
          tail_pri_p1  <= push_pri;
        end
      end
      TWO: begin
        if (write) begin
          head_data_p1 <= tail_data_p1;
          head_pri_p1  <= tail_pri_p1;
        end
      end
      default: ;
    endcase
  end

`ifdef CHIPLIB_PRI_QUEUE_PUSH_STATS_EN
  function automatic logic [StatWidth-1:0] sat_inc(input logic [StatWidth-1:0] v);
    return (&v) ? v : v + StatWidth'(1);
  endfunction

  // Stage boundary: statistics; accepts count even when a flush discards them
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accept_count <= '0;
      stat_stall_count  <= '0;
    end else begin
      if (accept)
        stat_accept_count <= sat_inc(stat_accept_count);
      if ((state_q != EMPTY) && full)
        stat_stall_count <= sat_inc(stat_stall_count);
    end
  end
`endif

endmodule
